qupls4_dport_arb: RTL
=====================

Name: qupls4_dport_arb

Overview:
- Shares the NPORTS data-cache ports among NREQ requesters: memory-scheduler slot 0, memory-scheduler slot 1, page-table walker, and store-buffer drain.
- Registers one request per port per cycle.
- Tags each request with its source ID so responses can be routed back.
- Tracks in-flight requests per port and prevents starvation using age counters.
- Sits between the memory scheduler/LSQ and the data-cache port interface.

Parameters:
NREQ, 4, number of requesters (index 0 has the highest fixed preference on ties)
NPORTS, 2, number of data-cache ports
PAYLOAD_W, 128, packed memory-request width (address, size, opcode, LSQ index)
MAX_OUT, 2, maximum in-flight requests per port
STARVE_LIM, 8, age at which a waiting requester becomes "starved"

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
flush_i  in  1  pipeline flush; drops requests held in port registers
req_v_i  in  NREQ  request valid per requester
req_p0only_i  in  NREQ  request may only use port 0 (mem0-class ops)
req_payload_i  in  NREQ*PAYLOAD_W  request payloads
req_rdy_o  out  NREQ  request accepted this cycle (combinational)
port_v_o  out  NPORTS  port register holds a valid request
port_payload_o  out  NPORTS*PAYLOAD_W  request to cache
port_src_o  out  NPORTS*$clog2(NREQ)  source requester ID
port_rdy_i  in  NPORTS  cache accepts port request
port_done_i  in  NPORTS  one in-flight request on the port completed
out_cnt_o  out  NPORTS*$clog2(MAX_OUT+1)  in-flight count per port (debug/perf)

Behaviour:
- Reset: all outputs 0. The rr pointer, age counters and out_cnt are all 0. A reset mid-operation discards everything, with no handshakes completed.

Port free condition:
- Port p is free when (!port_v_o[p] || port_rdy_i[p]) && out_cnt[p] + port_v_o[p] < MAX_OUT && !flush_i.

Eligibility:
- Requester r is eligible for port 0 when req_v_i[r] is set.
- It is eligible for port 1 when req_v_i[r] && !req_p0only_i[r] and it is not the port-0 winner.

Winner selection (per port, ports filled in order 0 then 1):
- If any eligible requester has age >= STARVE_LIM, the lowest-index starved requester wins.
- Otherwise the winner is the first eligible requester at or after rr, wrapping modulo NREQ.

Grant and handshake:
- req_rdy_o[r] = 1 iff r won a free port. At most one grant per requester per cycle.
- On a grant, at the next clk edge: port_v_o[p] <= 1; port_payload_o[p] and port_src_o[p] are loaded.
- Latency from request to port is one cycle.
- A port register with no new grant clears when port_rdy_i is high; otherwise it holds stable. Payload must not change while port_v_o && !port_rdy_i.

rr pointer:
- When at least one grant occurs, rr <= (highest-numbered port winner's index + 1) mod NREQ. Otherwise rr holds.

Age counters (4-bit, per requester):
- req_v_i && !req_rdy_o: increment, saturating at 15.
- Accepted, or req_v_i low: cleared to 0.

out_cnt[p]:
- +1 on port_v_o[p] && port_rdy_i[p]; −1 on port_done_i[p].
- Both in the same cycle: unchanged.
- port_done_i at 0: ignored (assertion fires).
- Handshake at MAX_OUT cannot occur because of the free condition.

flush_i:
- Clears port_v_o at the next edge and suppresses all grants that cycle (req_rdy_o = 0). Ages are cleared.
- out_cnt is not cleared, because in-flight cache requests still return done.
- A handshake with port_rdy_i in the flush cycle still counts.

Boundary cases:
- Two requests with p0only set: only one is granted per cycle; the other ages.
- NPORTS = 1: the port-1 logic is absent.

Decomposition:
- Qupls4_pkg holds:
  - dport_req_t (packed PAYLOAD_W request struct)
  - dport_src_t ($clog2(NREQ) source ID)
  - constants DPORT_NREQ, DPORT_MAX_OUT, DPORT_STARVE_LIM
  - requester ID enumeration: DPR_MEM0, DPR_MEM1, DPR_PTW, DPR_SBUF
- One sub-module, qupls4_rr_pick: a parameterized round-robin find-first with a starvation override. It takes eligible, starved and rr, and returns winner and found. It is instantiated once per port.

Test Plan:
1. Single request: req_v=0001, port0 free → req_rdy=0001, next cycle port_v=01, port_src[0]=0, rr=1.
2. Round-robin: req_v=1111 held, ports always ready, no done → cycle 1 grants 0,1 (rr=2), cycle 2 grants 2,3 (rr=0). out_cnt reaches 2 on both ports; further grants blocked until port_done pulses.
3. p0only: req_v=0011, p0only=0011 → one grant per cycle (req0 then req1). Port 1 never valid.
4. Starvation: port1 held busy (port_rdy_i[1]=0). Requesters 0 and 3 request continuously with rr biased away from 3 → once age[3]=8, req3 wins port 0 ahead of req0.
5. Backpressure: port_rdy_i[0]=0 for 5 cycles with port_v_o[0]=1 → payload stable, no grant to port 0. On ready, out_cnt[0] increments by 1.
6. Flush and reset: flush_i while port_v_o=11 → next cycle port_v_o=00, out_cnt unchanged, ages 0. rst mid-stream → all outputs 0 next cycle.

Source files
------------

// File: rtl/qupls4_pkg.sv
// Shared types and constants for the Qupls4 data-cache port arbiter.
package qupls4_pkg;

   localparam int DPORT_NREQ       = 4;
   localparam int DPORT_NPORTS     = 2;
   localparam int DPORT_PAYLOAD_W  = 128;
   localparam int DPORT_MAX_OUT    = 2;
   localparam int DPORT_STARVE_LIM = 8;
   localparam int DPORT_SRC_W      = $clog2(DPORT_NREQ);
   localparam int DPORT_AGE_W      = 4;

   typedef logic [DPORT_SRC_W-1:0] dport_src_t;

   typedef enum logic [DPORT_SRC_W-1:0] {
      DPR_MEM0,
      DPR_MEM1,
      DPR_PTW,
      DPR_SBUF
   } dport_rid_e;

   typedef struct packed {
      logic [63:0] addr;
      logic [3:0]  size;
      logic [7:0]  opcode;
      logic [7:0]  lsq_idx;
      logic [43:0] rsvd;
   } dport_req_t;

endpackage

// File: rtl/qupls4_rr_pick.sv
// Round-robin find-first starting at rr, overridden by the
// lowest-index starved eligible requester.
module qupls4_rr_pick #(
   parameter int N = 4,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] elig_i,
   input  logic [N-1:0] starved_i,
   input  logic [W-1:0] rr_i,
   output logic [W-1:0] win_o,
   output logic         found_o
);

   logic [N-1:0] stv;
   int           idx;

   assign stv = elig_i & starved_i;

   // Scanning downward leaves the first hit in win_o.
   always_comb begin
      win_o   = '0;
      idx     = 0;
      found_o = |elig_i;
      if (|stv) begin
         for (int i = N - 1; i >= 0; i--)
            if (stv[i]) win_o = W'(i);
      end else begin
         for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(rr_i) + i) % N;
            if (elig_i[idx]) win_o = W'(idx);
         end
      end
   end

endmodule

// File: rtl/qupls4_dport_arb.sv
// Shares the data-cache ports among the memory scheduler slots,
// the page-table walker and the store-buffer drain.
module qupls4_dport_arb
   import qupls4_pkg::*;
#(
   parameter int NREQ       = DPORT_NREQ,
   parameter int NPORTS     = DPORT_NPORTS,
   parameter int PAYLOAD_W  = DPORT_PAYLOAD_W,
   parameter int MAX_OUT    = DPORT_MAX_OUT,
   parameter int STARVE_LIM = DPORT_STARVE_LIM,
   parameter int SRC_W      = $clog2(NREQ),
   parameter int CNT_W      = $clog2(MAX_OUT + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush_i,
   input  logic [NREQ-1:0]             req_v_i,
   input  logic [NREQ-1:0]             req_p0only_i,
   input  logic [NREQ*PAYLOAD_W-1:0]   req_payload_i,
   output logic [NREQ-1:0]             req_rdy_o,
   output logic [NPORTS-1:0]           port_v_o,
   output logic [NPORTS*PAYLOAD_W-1:0] port_payload_o,
   output logic [NPORTS*SRC_W-1:0]     port_src_o,
   input  logic [NPORTS-1:0]           port_rdy_i,
   input  logic [NPORTS-1:0]           port_done_i,
   output logic [NPORTS*CNT_W-1:0]     out_cnt_o
);

   logic [SRC_W-1:0]       rr_q, rr_d;
   logic [DPORT_AGE_W-1:0] age_q [NREQ];
   logic [DPORT_AGE_W-1:0] age_d [NREQ];
   logic [NREQ-1:0]        starve;
   logic [NPORTS-1:0]      gnt;
   logic [SRC_W-1:0]       win [NPORTS];

   for (genvar p = 0; p < NPORTS; p++) begin : g_port
      logic [NREQ-1:0]      tk_in, tk_out, elig, onehot;
      logic [SRC_W-1:0]     w;
      logic                 found, free_p, hs, dn;
      logic                 v_q;
      logic [PAYLOAD_W-1:0] pay_q;
      logic [SRC_W-1:0]     src_q;
      logic [CNT_W-1:0]     cnt_q, cnt_d;

      // Later ports only see requesters not already granted.
      if (p == 0) begin : g_first
         assign tk_in = '0;
         assign elig  = req_v_i;
      end else begin : g_next
         assign tk_in = g_port[p-1].tk_out;
         assign elig  = req_v_i & ~req_p0only_i & ~tk_in;
      end

      qupls4_rr_pick #(
         .N (NREQ),
         .W (SRC_W)
      ) u_pick (
         .elig_i    (elig),
         .starved_i (starve),
         .rr_i      (rr_q),
         .win_o     (w),
         .found_o   (found)
      );

      assign free_p = (!v_q || port_rdy_i[p])
                   && ((int'(cnt_q) + int'(v_q)) < MAX_OUT)
                   && !flush_i && !rst;
      assign hs     = v_q && port_rdy_i[p];
      assign dn     = port_done_i[p] && (cnt_q != '0 || hs);

      always_comb begin
         onehot    = '0;
         onehot[w] = free_p && found;
      end

      assign tk_out = tk_in | onehot;
      assign gnt[p] = free_p && found;
      assign win[p] = w;

      always_comb begin
         cnt_d = cnt_q;
         if (hs && !dn)      cnt_d = cnt_q + 1'b1;
         else if (dn && !hs) cnt_d = cnt_q - 1'b1;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            v_q   <= 1'b0;
            pay_q <= '0;
            src_q <= '0;
            cnt_q <= '0;
         end else begin
            if (gnt[p]) begin
               v_q   <= 1'b1;
               pay_q <= req_payload_i[w*PAYLOAD_W +: PAYLOAD_W];
               src_q <= w;
            end else if (port_rdy_i[p] || flush_i) begin
               v_q   <= 1'b0;
            end
            cnt_q <= cnt_d;
         end
      end

      a_done_uflow: assert property (@(posedge clk) disable iff (rst)
         !(port_done_i[p] && cnt_q == '0 && !hs));

      assign port_v_o[p]                          = v_q;
      assign port_payload_o[p*PAYLOAD_W +: PAYLOAD_W] = pay_q;
      assign port_src_o[p*SRC_W +: SRC_W]         = src_q;
      assign out_cnt_o[p*CNT_W +: CNT_W]          = cnt_q;
   end

   assign req_rdy_o = g_port[NPORTS-1].tk_out;

   always_comb begin
      for (int r = 0; r < NREQ; r++)
         starve[r] = int'(age_q[r]) >= STARVE_LIM;
   end

   always_comb begin
      rr_d = rr_q;
      for (int p = 0; p < NPORTS; p++)
         if (gnt[p])
            rr_d = (int'(win[p]) == NREQ - 1) ? '0 : win[p] + 1'b1;
      for (int r = 0; r < NREQ; r++) begin
         age_d[r] = '0;
         if (!flush_i && req_v_i[r] && !req_rdy_o[r])
            age_d[r] = (&age_q[r]) ? age_q[r] : age_q[r] + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q <= '0;
         for (int r = 0; r < NREQ; r++) age_q[r] <= '0;
      end else begin
         rr_q <= rr_d;
         for (int r = 0; r < NREQ; r++) age_q[r] <= age_d[r];
      end
   end

endmodule
